// File: rtl/layer_generator_pkg.sv
// Shared definitions for the falling-block layer generator: layer width, LFSR taps,
// FSM encodings and the Galois LFSR step used by every random source in the game.
package layer_generator_pkg;

    localparam int          LAYER_W   = 7;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          CNT_W     = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_FILL  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    // Right-shifting Galois step: the bit shifted out selects whether the taps are applied.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        if (cur[0]) begin
            shifted = shifted ^ LFSR_MASK;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/layer_generator_lfsr16.sv
// 16-bit Galois LFSR with a seed that can never lock up at zero; advances one step
// per cycle while advance is high.
module lfsr16
    import layer_generator_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] state_out
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_out = lfsr_q;

endmodule

// File: rtl/layer_generator.sv
// Produces each new 7-column layer from an LFSR, keeps a reachable solid path block,
// and issues the initial load_layer burst that fills the screen.
module layer_generator
    import layer_generator_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          NUM_LAYERS = 5,
    parameter int          INIT_GAP   = 4,
    parameter int          PATH_START = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       module_en,
    input  logic       jump_left,
    input  logic       jump_right,
    output logic [0:6] layer_map_out,
    output logic [0:6] block_type_out,
    output logic [0:6] bonus_map_out,
    output logic       load_layer,
    output logic       init_done
);

    localparam cnt_t       NUM_LAYERS_C = cnt_t'(NUM_LAYERS);
    localparam cnt_t       GAP_LAST     = cnt_t'(INIT_GAP - 2);
    localparam logic [2:0] PATH_START_C = 3'(PATH_START);

    // Handshake: jump_left/jump_right are single-cycle pulses with no back-pressure; the
    // consumer latches whatever is on the layer outputs in the cycle it raises a jump.

    state_t     state_q, state_d;
    logic [2:0] path_q, path_d;
    logic [0:6] map_q, map_d;
    logic [0:6] type_q, type_d;
    logic [0:6] bonus_q, bonus_d;
    logic       load_q, load_d;
    logic       done_q, done_d;
    logic       pending_q, pending_d;
    cnt_t       gap_q, gap_d;
    cnt_t       init_cnt_q, init_cnt_d;

    logic        lfsr_adv;
    logic [15:0] lfsr;

    logic       jump;
    logic [2:0] nc;
    logic [6:0] rnd_lo, rnd_mid, rnd_hi;
    logic [0:6] gen_map, gen_type, gen_bonus;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .advance  (lfsr_adv),
        .state_out(lfsr)
    );

    always_comb begin
        state_d    = state_q;
        path_d     = path_q;
        map_d      = map_q;
        type_d     = type_q;
        bonus_d    = bonus_q;
        load_d     = 1'b0;
        done_d     = done_q;
        pending_d  = pending_q;
        gap_d      = gap_q;
        init_cnt_d = init_cnt_q;
        lfsr_adv   = 1'b0;

        jump    = jump_left | jump_right;
        rnd_lo  = lfsr[6:0];
        rnd_mid = lfsr[9:3];
        rnd_hi  = lfsr[13:7];

        // Edge columns bounce back inwards so the path never leaves the board.
        if (path_q == 3'd0) begin
            nc = 3'd1;
        end else if (path_q == 3'd6) begin
            nc = 3'd5;
        end else if (lfsr[15]) begin
            nc = path_q + 3'd1;
        end else begin
            nc = path_q - 3'd1;
        end

        gen_map       = rnd_lo | rnd_hi;
        gen_map[nc]   = 1'b1;
        gen_type      = gen_map & (rnd_hi | rnd_mid);
        gen_type[nc]  = 1'b1;
        gen_bonus     = gen_type & rnd_lo & {7{lfsr[14]}};

        if (!module_en) begin
            state_d   = ST_IDLE;
            map_d     = '0;
            type_d    = '0;
            bonus_d   = '0;
            done_d    = 1'b0;
            pending_d = 1'b0;
            gap_d     = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_GEN;
                    init_cnt_d = CNT_ZERO;
                    gap_d      = CNT_ZERO;
                end
                ST_GEN: begin
                    lfsr_adv = 1'b1;
                    map_d    = gen_map;
                    type_d   = gen_type;
                    bonus_d  = gen_bonus;
                    path_d   = nc;
                    if (jump) begin
                        pending_d = 1'b1;
                    end
                    if (init_cnt_q < NUM_LAYERS_C) begin
                        state_d = ST_FILL;
                        load_d  = 1'b1;
                        gap_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_READY;
                        done_d  = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (jump) begin
                        pending_d = 1'b1;
                    end
                    if (gap_q == CNT_ZERO) begin
                        init_cnt_d = init_cnt_q + CNT_ONE;
                    end
                    // FILL plus the following GEN cycle spans INIT_GAP clocks per pulse.
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_GEN;
                        gap_d   = CNT_ZERO;
                    end else begin
                        gap_d = gap_q + CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (jump || pending_q) begin
                        state_d   = ST_GEN;
                        pending_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            path_q     <= PATH_START_C;
            map_q      <= '0;
            type_q     <= '0;
            bonus_q    <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            gap_q      <= CNT_ZERO;
            init_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            path_q     <= path_d;
            map_q      <= map_d;
            type_q     <= type_d;
            bonus_q    <= bonus_d;
            load_q     <= load_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            gap_q      <= gap_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign layer_map_out  = map_q;
    assign block_type_out = type_q;
    assign bonus_map_out  = bonus_q;
    assign load_layer     = load_q;
    assign init_done      = done_q;

endmodule

// File: tb/tb_layer_generator.sv
// Directed bench for layer_generator: fill burst timing, layer contents against a small
// reference model, path edge cases, double jumps, pending jumps and module_en drop-out.
module tb_layer_generator;

    localparam int NUM_LAYERS = 5;
    localparam int INIT_GAP   = 4;

    logic       clk;
    logic       rst;
    logic       module_en;
    logic       jump_left;
    logic       jump_right;
    logic [0:6] layer_map_out, block_type_out, bonus_map_out;
    logic       load_layer, init_done;
    logic [0:6] z_map, z_type, z_bonus;
    logic       z_load, z_done;
    logic [0:6] g_map, g_type, g_bonus;
    logic       g_load, g_done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] m_lfsr;
    logic [2:0]  m_path;
    logic [0:6]  e_map, e_type, e_bonus;

    layer_generator #(.SEED(16'hACE1), .NUM_LAYERS(NUM_LAYERS), .INIT_GAP(INIT_GAP), .PATH_START(3)) u_dut (
        .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
        .layer_map_out(layer_map_out), .block_type_out(block_type_out), .bonus_map_out(bonus_map_out),
        .load_layer(load_layer), .init_done(init_done)
    );

    layer_generator #(.SEED(16'h0000), .NUM_LAYERS(NUM_LAYERS), .INIT_GAP(INIT_GAP), .PATH_START(0)) u_zero (
        .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
        .layer_map_out(z_map), .block_type_out(z_type), .bonus_map_out(z_bonus),
        .load_layer(z_load), .init_done(z_done)
    );

    layer_generator #(.SEED(16'hACE1), .NUM_LAYERS(NUM_LAYERS), .INIT_GAP(INIT_GAP), .PATH_START(6)) u_edge (
        .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
        .layer_map_out(g_map), .block_type_out(g_type), .bonus_map_out(g_bonus),
        .load_layer(g_load), .init_done(g_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference layer builder written from the block description.
    task automatic model_gen();
        logic [2:0] nc;
        logic [6:0] lo, mid, hi;
        lo  = m_lfsr[6:0];
        mid = m_lfsr[9:3];
        hi  = m_lfsr[13:7];
        if (m_path == 3'd0)      nc = 3'd1;
        else if (m_path == 3'd6) nc = 3'd5;
        else if (m_lfsr[15])     nc = m_path + 3'd1;
        else                     nc = m_path - 3'd1;
        e_map       = lo | hi;
        e_map[nc]   = 1'b1;
        e_type      = e_map & (hi | mid);
        e_type[nc]  = 1'b1;
        e_bonus     = e_type & lo & {7{m_lfsr[14]}};
        m_path      = nc;
        m_lfsr      = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic check_layer(input string tag);
        check({tag, "_map"},   32'(layer_map_out),  32'(e_map));
        check({tag, "_type"},  32'(block_type_out), 32'(e_type));
        check({tag, "_bonus"}, 32'(bonus_map_out),  32'(e_bonus));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_map"},  32'(layer_map_out),  32'h0);
        check({tag, "_type"}, 32'(block_type_out), 32'h0);
        check({tag, "_bonus"}, 32'(bonus_map_out), 32'h0);
        check({tag, "_load"}, 32'(load_layer),     32'h0);
        check({tag, "_done"}, 32'(init_done),      32'h0);
    endtask

    task automatic do_jump(input logic l, input logic r, input string tag);
        jump_left  = l;
        jump_right = r;
        step();
        jump_left  = 1'b0;
        jump_right = 1'b0;
        check_layer({tag, "_gen_hold"});
        step();
        model_gen();
        check_layer(tag);
        check({tag, "_path_solid"}, 32'(layer_map_out[m_path] & block_type_out[m_path]), 32'h1);
        check({tag, "_bonus_gap"}, 32'(bonus_map_out & ~block_type_out), 32'h0);
    endtask

    task automatic hold_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check_layer(tag);
        end
    endtask

    // Called in IDLE with module_en just raised; stop_after=0 runs the whole fill.
    task automatic run_fill(input int stop_after, input bit aux);
        int cyc, last, pulses;
        cyc = 0;
        last = 0;
        pulses = 0;
        while (init_done !== 1'b1 && cyc < 60 && !(stop_after != 0 && pulses == stop_after)) begin
            step();
            cyc++;
            if (load_layer === 1'b1) begin
                model_gen();
                check_layer("fill");
                check("fill_done_low", 32'(init_done), 32'h0);
                if (pulses == 0) check("fill_first_latency", 32'(cyc), 32'd2);
                else             check("fill_pulse_gap", 32'(cyc - last), 32'(INIT_GAP));
                if (aux && pulses == 0) begin
                    check("seed_l1_map", 32'(layer_map_out), 32'h7D);
                    check("seed_l1_type", 32'(block_type_out), 32'h5D);
                    check("zero_seed_map", 32'(z_map), 32'h21);
                    check("zero_seed_type", 32'(z_type), 32'h20);
                    check("zero_seed_bonus", 32'(z_bonus), 32'h0);
                    check("edge6_map", 32'(g_map), 32'h7B);
                    check("edge6_type", 32'(g_type), 32'h5B);
                    check("edge_load", 32'({z_load, g_load}), 32'h3);
                end
                if (aux && pulses == 1) begin
                    check("seed_l2_map", 32'(layer_map_out), 32'h76);
                    check("seed_l2_type", 32'(block_type_out), 32'h46);
                    check("seed_l2_bonus", 32'(bonus_map_out), 32'h40);
                end
                pulses++;
                last = cyc;
            end
        end
        if (stop_after != 0) begin
            check("partial_pulses", 32'(pulses), 32'(stop_after));
            return;
        end
        check("fill_pulses", 32'(pulses), 32'(NUM_LAYERS));
        check("init_done_high", 32'(init_done), 32'h1);
        check("init_done_latency", 32'(cyc - last), 32'(INIT_GAP));
        check("ready_no_load", 32'(load_layer), 32'h0);
        model_gen();
        check_layer("ready");
    endtask

    initial begin
        rst        = 1'b1;
        module_en  = 1'b0;
        jump_left  = 1'b0;
        jump_right = 1'b0;
        m_lfsr     = 16'hACE1;
        m_path     = 3'd3;

        // Reset state.
        step();
        step();
        check_cleared("reset");
        check("reset_aux_done", 32'({z_done, g_done}), 32'h0);
        rst = 1'b0;
        step();
        check_cleared("idle_en_low");

        // Initial fill burst.
        module_en = 1'b1;
        run_fill(0, 1'b1);

        // Random single/double jumps along the path.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       do_jump(1'b1, 1'b0, "rand_left");
                1:       do_jump(1'b0, 1'b1, "rand_right");
                default: do_jump(1'b1, 1'b1, "rand_both");
            endcase
        end

        // Both jumps in one clock give exactly one advance.
        do_jump(1'b1, 1'b1, "both");
        hold_check(3, "both_hold");
        do_jump(1'b1, 1'b0, "after_both");

        // Jump during GEN alone is remembered and produces one extra layer.
        jump_left = 1'b1;
        step();
        jump_left  = 1'b0;
        jump_right = 1'b1;
        step();
        jump_right = 1'b0;
        model_gen();
        check_layer("pend_first");
        step();
        check_layer("pend_gen_hold");
        step();
        model_gen();
        check_layer("pend_extra");
        check("pend_done", 32'(init_done), 32'h1);
        hold_check(3, "pend_hold");

        // Jump during GEN plus another jump the next clock: still only one extra layer.
        jump_left = 1'b1;
        step();
        step();
        model_gen();
        check_layer("drop_first");
        step();
        jump_left = 1'b0;
        step();
        model_gen();
        check_layer("drop_extra");
        hold_check(3, "drop_hold");
        do_jump(1'b0, 1'b1, "after_drop");

        // module_en low from READY, then mid-fill, then a fresh fill without reseeding.
        module_en = 1'b0;
        step();
        check_cleared("en_low_ready");
        module_en = 1'b1;
        run_fill(2, 1'b0);
        module_en = 1'b0;
        step();
        check_cleared("en_low_fill");
        step();
        step();
        check_cleared("en_low_idle");
        module_en = 1'b1;
        run_fill(0, 1'b0);
        do_jump(1'b1, 1'b0, "refill_jump");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
